// File: rtl/data_mem_if.sv
// Operand-bus request channel and registered response channel between the
// execute-stage drivers (master) and the memory-stage responder (slave).
interface data_mem_if #(
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [15:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  // Handshake: a beat transfers on a rising edge where valid && ready are both
  // high; valid never depends on ready, and a held response keeps its payload.
  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/data_mem_unit.sv
// Memory-stage responder: data memory, stack pointer and a one-deep response register.
// Optional macro STACK_GUARD_EN makes PUSH at sp==0 / POP at sp==SP_INIT fault instead of wrapping.
module data_mem_unit #(
  parameter int          DATA_W  = 16,
  parameter int          ADDR_W  = 11,
  parameter int unsigned SP_INIT = (1 << ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  data_mem_if.slave         bus,
  output logic [ADDR_W-1:0] sp
);
  localparam int              DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] SP_TOP = SP_INIT[ADDR_W-1:0];

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDM  = 3'b001;
  localparam logic [2:0] OP_LDD  = 3'b010;
  localparam logic [2:0] OP_STD  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_sp;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;

  logic              w_accept;
  logic              w_addr_ok;
  logic [ADDR_W-1:0] w_idx;
  logic [ADDR_W-1:0] w_sp_inc;
  logic [ADDR_W-1:0] w_sp_dec;
  logic              w_push_err;
  logic              w_pop_err;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_raddr;
  logic [DATA_W-1:0] w_imm;
  logic              w_err;
  logic [ADDR_W-1:0] w_sp_nxt;

  assign bus.req_ready = !r_rsp_valid || bus.rsp_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign sp            = r_sp;

  assign w_accept  = bus.req_valid && bus.req_ready && (bus.req_op != OP_NOP);
  assign w_addr_ok = (bus.req_addr >> ADDR_W) == 16'd0;
  assign w_idx     = bus.req_addr[ADDR_W-1:0];
  assign w_sp_inc  = r_sp + ADDR_W'(1);
  assign w_sp_dec  = r_sp - ADDR_W'(1);

`ifdef STACK_GUARD_EN
  assign w_push_err = (r_sp == '0);
  assign w_pop_err  = (r_sp == SP_TOP);
`else
  assign w_push_err = 1'b0;
  assign w_pop_err  = 1'b0;
`endif

  always_comb begin
    w_we     = 1'b0;
    w_waddr  = w_idx;
    w_rd_en  = 1'b0;
    w_raddr  = w_idx;
    w_imm    = '0;
    w_err    = 1'b0;
    w_sp_nxt = r_sp;
    case (bus.req_op)
      OP_NOP: ;
      OP_LDM: w_imm = bus.req_wdata;
      OP_LDD: begin
        if (w_addr_ok) w_rd_en = 1'b1;
        else           w_err   = 1'b1;
      end
      OP_STD: begin
        if (w_addr_ok) w_we  = 1'b1;
        else           w_err = 1'b1;
      end
      // Stack grows downward: store at sp then decrement; increment then load.
      OP_PUSH: begin
        if (w_push_err) begin
          w_err = 1'b1;
        end else begin
          w_we     = 1'b1;
          w_waddr  = r_sp;
          w_sp_nxt = w_sp_dec;
        end
      end
      OP_POP: begin
        if (w_pop_err) begin
          w_err = 1'b1;
        end else begin
          w_rd_en  = 1'b1;
          w_raddr  = w_sp_inc;
          w_sp_nxt = w_sp_inc;
        end
      end
      default: w_err = 1'b1;
    endcase
  end

  // Array is never reset; a write at edge N is already visible to a read at N+1.
  always_ff @(posedge clk) begin
    if (w_accept && w_we) r_mem[w_waddr] <= bus.req_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp        <= SP_TOP;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_sp        <= w_sp_nxt;
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_rd_en ? r_mem[w_raddr] : w_imm;
      r_rsp_err   <= w_err;
    end else if (bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_data_mem_unit.sv
// Directed-vector bench for data_mem_unit; expectations follow STACK_GUARD_EN when defined.
module tb_data_mem_unit;
  logic        clk;
  logic        rst_n;
  logic [10:0] sp;
  int          n_checks;
  int          n_fail;
  logic [15:0] exp_q[$];

  data_mem_if #(.DATA_W(16)) bus ();

  data_mem_unit #(.DATA_W(16), .ADDR_W(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .sp    (sp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [15:0] data, input logic err);
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_data"},  32'(bus.rsp_data),  32'(data));
    check({tag, "_err"},   32'(bus.rsp_err),   32'(err));
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wd);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op    = 3'b000;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'b000;
    bus.req_addr  = 16'h0;
    bus.req_wdata = 16'h0;
    bus.rsp_ready = 1'b1;
    rst_n         = 1'b0;

    // 1. reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_sp",        32'(sp),            32'h7FF);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("idle_sp",        32'(sp),            32'h7FF);

    // 2. store then load next cycle
    issue(3'b011, 16'h0010, 16'hBEEF);
    check_rsp("std", 16'h0000, 1'b0);
    issue(3'b010, 16'h0010, 16'h0000);
    check_rsp("ldd_raw", 16'hBEEF, 1'b0);
    idle();
    check("ldd_drain_valid", 32'(bus.rsp_valid), 32'd0);

    // 3. back-to-back stack ops
    issue(3'b100, 16'h0, 16'h1234);
    check_rsp("push1", 16'h0000, 1'b0);
    check("push1_sp", 32'(sp), 32'h7FE);
    issue(3'b100, 16'h0, 16'h5678);
    check_rsp("push2", 16'h0000, 1'b0);
    check("push2_sp", 32'(sp), 32'h7FD);
    exp_q.push_back(16'h5678);
    exp_q.push_back(16'h1234);
    issue(3'b101, 16'h0, 16'h0);
    check_rsp("pop1", exp_q.pop_front(), 1'b0);
    check("pop1_sp", 32'(sp), 32'h7FE);
    issue(3'b101, 16'h0, 16'h0);
    check_rsp("pop2", exp_q.pop_front(), 1'b0);
    check("pop2_sp", 32'(sp), 32'h7FF);

    // 4. LDM held by back-pressure with a waiting request
    issue(3'b001, 16'h0, 16'hA5A5);
    check_rsp("ldm", 16'hA5A5, 1'b0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_op    = 3'b001;
    bus.req_wdata = 16'h0042;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      check_rsp("hold", 16'hA5A5, 1'b0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("release_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    check_rsp("waiting_ldm", 16'h0042, 1'b0);
    idle();
    check("once_valid", 32'(bus.rsp_valid), 32'd0);

    // 5. error cases
    issue(3'b010, 16'h0800, 16'h0);
    check_rsp("ldd_oor", 16'h0000, 1'b1);
    issue(3'b011, 16'h0810, 16'hDEAD);
    check_rsp("std_oor", 16'h0000, 1'b1);
    issue(3'b010, 16'h0010, 16'h0);
    check_rsp("std_oor_nowrite", 16'hBEEF, 1'b0);
    issue(3'b111, 16'h0, 16'h0);
    check_rsp("op7", 16'h0000, 1'b1);
    check("op7_sp", 32'(sp), 32'h7FF);
    issue(3'b110, 16'h0, 16'h0);
    check_rsp("op6", 16'h0000, 1'b1);
    issue(3'b000, 16'h0, 16'h0);
    check("nop_valid", 32'(bus.rsp_valid), 32'd0);
    check("nop_sp",    32'(sp),            32'h7FF);
    issue(3'b011, 16'h0000, 16'h0C0D);
    check_rsp("std0", 16'h0000, 1'b0);
    issue(3'b101, 16'h0, 16'h0);
`ifdef STACK_GUARD_EN
    check_rsp("pop_top", 16'h0000, 1'b1);
    check("pop_top_sp", 32'(sp), 32'h7FF);
`else
    check_rsp("pop_top", 16'h0C0D, 1'b0);
    check("pop_top_sp", 32'(sp), 32'h000);
    issue(3'b100, 16'h0, 16'h7777);
    check_rsp("push_bottom", 16'h0000, 1'b0);
    check("push_bottom_sp", 32'(sp), 32'h7FF);
    issue(3'b010, 16'h0000, 16'h0);
    check_rsp("push_bottom_rd", 16'h7777, 1'b0);
`endif

    // 6. asynchronous reset while a response is held
    issue(3'b011, 16'h0020, 16'h5A5A);
    check_rsp("std20", 16'h0000, 1'b0);
    issue(3'b100, 16'h0, 16'h1111);
    check("push_pre_rst_sp", 32'(sp), 32'h7FE);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op    = 3'b000;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    check("held_valid", 32'(bus.rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_sp",    32'(sp),            32'h7FF);
    check("arst_data",  32'(bus.rsp_data),  32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.rsp_ready = 1'b1;
    issue(3'b010, 16'h0020, 16'h0);
    check_rsp("post_rst_ld20", 16'h5A5A, 1'b0);
    issue(3'b010, 16'h07FF, 16'h0);
    check_rsp("post_rst_ld7ff", 16'h1111, 1'b0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
